// File: rtl/psum_requant_pkg.sv
// rtl/psum_requant_pkg.sv - shared FSM encoding and int8 limits for the psum requant/pack stage
package psum_requant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  // Width of the byte-lane index within a packed word.
  function automatic int lane_bits(input int num_byte);
    return (num_byte > 1) ? $clog2(num_byte) : 1;
  endfunction

endpackage

// File: rtl/requant_sat_unit.sv
// rtl/requant_sat_unit.sv - registered bias + round + shift + saturate of one psum to int8
// Optional PSUM_RELU_EN: negative results clamp to 0 before saturation.
module requant_sat_unit
  import psum_requant_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BIT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] psum,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic [4:0]            shift,
  output logic                  out_vld,
  output logic [BIT_WIDTH-1:0]  out_byte
);

  // Two guard bits: one for the bias sum, one for the rounding increment on top of it.
  localparam int SW = DATA_WIDTH + 2;
  localparam logic signed [SW-1:0] SAT_HI = SW'(INT8_MAX);
`ifdef PSUM_RELU_EN
  localparam logic signed [SW-1:0] SAT_LO = '0;
`else
  localparam logic signed [SW-1:0] SAT_LO = SW'(INT8_MIN);
`endif

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic [SW-1:0]        rnd;
  logic [BIT_WIDTH-1:0] sat_byte;

  always_comb begin
    sum = $signed({{2{psum[DATA_WIDTH-1]}}, psum}) + $signed({{2{bias[DATA_WIDTH-1]}}, bias});
    // Half an LSB of the shifted result; collapses to zero when shift is 0.
    rnd = (SW'(1) << shift) >> 1;
    shifted = (sum + $signed(rnd)) >>> shift;
    if (shifted > SAT_HI) begin
      sat_byte = SAT_HI[BIT_WIDTH-1:0];
    end else if (shifted < SAT_LO) begin
      sat_byte = SAT_LO[BIT_WIDTH-1:0];
    end else begin
      sat_byte = shifted[BIT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_byte <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_byte <= sat_byte;
      end
    end
  end

endmodule

// File: rtl/psum_requant_packer.sv
// rtl/psum_requant_packer.sv - streams psums out of BRAM, requantizes to int8 and packs 4 per word
// Optional PSUM_RELU_EN (in requant_sat_unit) clamps negative results to 0.
module psum_requant_packer
  import psum_requant_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_BYTE   = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
  input  logic [REG_WIDTH-1:0]  i_conf_bias,
  input  logic [4:0]            i_conf_shift,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] psum_addr,
  output logic                  psum_enb,
  input  logic [DATA_WIDTH-1:0] psum_odat,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_idat,
  output logic [NUM_BYTE-1:0]   out_wren,
  output logic                  out_enb
);

  localparam int LW = lane_bits(NUM_BYTE);

  state_t               state;
  logic [REG_WIDTH-1:0] cfg_size;
  logic [REG_WIDTH-1:0] cfg_bias;
  logic [4:0]           cfg_shift;
  logic [REG_WIDTH-1:0] cnt;
  logic                 d_vld;
  logic                 d_last;
  logic [REG_WIDTH-1:0] d_idx;
  logic                 r_vld;
  logic                 r_last;
  logic [REG_WIDTH-1:0] r_idx;
  logic [BIT_WIDTH-1:0] r_byte;
  logic [LW-1:0]        lane;
  logic                 wr;
  logic [NUM_BYTE-1:0]  mask;
  logic [DATA_WIDTH-1:0] pack;
  logic [DATA_WIDTH-1:0] merged;

  requant_sat_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_sat (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (d_vld),
    .psum    (psum_odat),
    .bias    (DATA_WIDTH'(cfg_bias)),
    .shift   (cfg_shift),
    .out_vld (r_vld),
    .out_byte(r_byte)
  );

  // The write port is formed from the registered result so a word lands the cycle its byte is ready.
  always_comb begin
    lane   = r_idx[LW-1:0];
    wr     = r_vld && (r_last || (lane == LW'(NUM_BYTE - 1)));
    merged = pack | (DATA_WIDTH'(r_byte) << (int'(lane) * BIT_WIDTH));
    mask   = '0;
    for (int k = 0; k < NUM_BYTE; k++) begin
      mask[k] = (k <= int'(lane));
    end
    out_wren = wr ? mask : '0;
    out_idat = wr ? merged : '0;
    out_addr = wr ? ADDR_WIDTH'(r_idx >> LW) : '0;
    out_enb  = |out_wren;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_size  <= '0;
      cfg_bias  <= '0;
      cfg_shift <= '0;
      cnt       <= '0;
      psum_addr <= '0;
      psum_enb  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      d_vld     <= 1'b0;
      d_last    <= 1'b0;
      d_idx     <= '0;
      r_last    <= 1'b0;
      r_idx     <= '0;
      pack      <= '0;
    end else begin
      o_done <= 1'b0;
      d_vld  <= psum_enb;
      d_last <= psum_enb && (cnt == cfg_size);
      d_idx  <= cnt;
      r_last <= d_last;
      r_idx  <= d_idx;
      if (r_vld) begin
        pack <= wr ? '0 : merged;
      end

      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            cfg_size  <= i_conf_outputsize;
            cfg_bias  <= i_conf_bias;
            cfg_shift <= i_conf_shift;
            cnt       <= '0;
            psum_addr <= '0;
            psum_enb  <= 1'b1;
            o_busy    <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          // Compare on equality so an outputsize of all-ones never needs a wrapping counter.
          if (cnt == cfg_size) begin
            psum_enb <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            cnt       <= cnt + 1'b1;
            psum_addr <= ADDR_WIDTH'(cnt + 1'b1);
          end
        end
        ST_DRAIN: begin
          // Once the data stage is empty, the last result is leaving the requant register now.
          if (!d_vld) begin
            o_done <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_requant_packer.sv
// tb/tb_psum_requant_packer.sv - self-checking bench for psum_requant_packer
// Expectations follow PSUM_RELU_EN when the bench is built with it.
module tb_psum_requant_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_conf_outputsize;
  logic [31:0] i_conf_bias;
  logic [4:0]  i_conf_shift;
  logic        o_busy;
  logic        o_done;
  logic [31:0] psum_addr;
  logic        psum_enb;
  logic [31:0] psum_odat;
  logic [31:0] out_addr;
  logic [31:0] out_idat;
  logic [3:0]  out_wren;
  logic        out_enb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int enb_err  = 0;

  logic [31:0] mem [64];
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_wren [$];
  int          wq_cyc  [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [3:0]  exp_wren [$];
  int          exp_cyc  [$];

  psum_requant_packer dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_conf_outputsize(i_conf_outputsize),
    .i_conf_bias      (i_conf_bias),
    .i_conf_shift     (i_conf_shift),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .psum_addr        (psum_addr),
    .psum_enb         (psum_enb),
    .psum_odat        (psum_odat),
    .out_addr         (out_addr),
    .out_idat         (out_idat),
    .out_wren         (out_wren),
    .out_enb          (out_enb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (psum_enb) psum_odat <= mem[psum_addr[5:0]];
  end

  always @(negedge clk) begin
    if (out_enb) begin
      wq_addr.push_back(out_addr);
      wq_data.push_back(out_idat);
      wq_wren.push_back(out_wren);
      wq_cyc.push_back(cyc);
    end
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (out_enb !== |out_wren) enb_err = enb_err + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] p, input logic [31:0] b, input int sh);
    longint s;
    s = longint'($signed(p)) + longint'($signed(b));
    if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
    s = s >>> sh;
`ifdef PSUM_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  task automatic build_expect(input int n, input logic [31:0] b, input int sh, input int t);
    logic [31:0] w;
    logic [3:0]  m;
    exp_addr.delete(); exp_data.delete(); exp_wren.delete(); exp_cyc.delete();
    w = '0;
    m = '0;
    for (int i = 0; i < n; i++) begin
      w[8*(i%4) +: 8] = ref_byte(mem[i], b, sh);
      m[i%4] = 1'b1;
      if (i % 4 == 3 || i == n - 1) begin
        exp_addr.push_back(32'(i / 4));
        exp_data.push_back(w);
        exp_wren.push_back(m);
        exp_cyc.push_back(t + 3 + i);
        w = '0;
        m = '0;
      end
    end
  endtask

  task automatic run_job(input int n, input logic [31:0] b, input logic [4:0] sh,
                         output int t, output int wbase, output int dbase);
    wbase = wq_addr.size();
    dbase = done_cnt;
    i_conf_outputsize = 32'(n - 1);
    i_conf_bias       = b;
    i_conf_shift      = sh;
    i_start           = 1'b1;
    t                 = cyc;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int dbase, input int limit, input string name);
    int k;
    for (k = 0; k < limit && done_cnt == dbase; k++) step();
    if (done_cnt == dbase) begin
      checks++;
      failures++;
      $display("FAIL %s done timeout: got no o_done within %0d cycles, expected one", name, limit);
    end
  endtask

  task automatic rand_mem(input int n);
    for (int i = 0; i < n; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
  endtask

  task automatic test_reset();
    checks++;
    if ({o_busy, o_done, psum_enb, out_enb} !== 4'b0) begin
      failures++;
      $display("FAIL reset flags: got busy=%b done=%b psum_enb=%b out_enb=%b expected all 0", o_busy, o_done, psum_enb, out_enb);
    end
    checks++;
    if (psum_addr !== 32'd0 || out_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset addr: got psum_addr=%h out_addr=%h expected 0", psum_addr, out_addr);
    end
    checks++;
    if (out_idat !== 32'd0 || out_wren !== 4'd0) begin
      failures++;
      $display("FAIL reset data: got idat=%h wren=%b expected 0", out_idat, out_wren);
    end
  endtask

  task automatic test_saturation();
    int t, wb, db;
    logic [31:0] exp_w;
`ifdef PSUM_RELU_EN
    exp_w = 32'h007F000A;
`else
    exp_w = 32'h807FFB0A;
`endif
    mem[0] = 32'd10; mem[1] = -32'sd5; mem[2] = 32'd300; mem[3] = -32'sd300;
    run_job(4, 32'd0, 5'd0, t, wb, db);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL sat busy: got %b expected 1", o_busy);
    end
    wait_done(db, 30, "sat");
    step();
    checks++;
    if (wq_addr.size() != wb + 1) begin
      failures++;
      $display("FAIL sat count: got %0d writes expected 1", wq_addr.size() - wb);
    end else if (wq_addr[wb] !== 32'd0 || wq_data[wb] !== exp_w || wq_wren[wb] !== 4'hF || wq_cyc[wb] != t + 6) begin
      failures++;
      $display("FAIL sat write: got addr=%h data=%h wren=%b cyc=%0d expected addr=0 data=%h wren=1111 cyc=%0d",
               wq_addr[wb], wq_data[wb], wq_wren[wb], wq_cyc[wb], exp_w, t + 6);
    end
    checks++;
    if (done_cyc != t + 7 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL sat done: got done_cyc=%0d busy=%b expected %0d busy=0", done_cyc, o_busy, t + 7);
    end
  endtask

  task automatic test_rounding();
    int t, wb, db;
    logic [31:0] e1, e2;
`ifdef PSUM_RELU_EN
    e1 = 32'h00000004; e2 = 32'h00000000;
`else
    e1 = 32'h0000FD04; e2 = 32'h000000EC;
`endif
    mem[0] = 32'd7; mem[1] = -32'sd7;
    run_job(2, 32'd0, 5'd1, t, wb, db);
    wait_done(db, 30, "round");
    step();
    checks++;
    if (wq_addr.size() != wb + 1 || wq_data[wb] !== e1 || wq_wren[wb] !== 4'b0011 || wq_cyc[wb] != t + 4) begin
      failures++;
      $display("FAIL round shift1: got writes=%0d data=%h expected 1 data=%h wren=0011", wq_addr.size() - wb, wq_data[wb], e1);
    end
    mem[0] = 32'd100;
    run_job(1, -32'sd120, 5'd0, t, wb, db);
    wait_done(db, 30, "bias");
    step();
    checks++;
    if (wq_addr.size() != wb + 1 || wq_data[wb] !== e2 || wq_wren[wb] !== 4'b0001 || wq_cyc[wb] != t + 3) begin
      failures++;
      $display("FAIL bias neg: got writes=%0d data=%h expected 1 data=%h wren=0001", wq_addr.size() - wb, wq_data[wb], e2);
    end
    checks++;
    if (done_cyc != t + 4) begin
      failures++;
      $display("FAIL n1 done: got %0d expected %0d", done_cyc, t + 4);
    end
  endtask

  task automatic test_partial();
    int t, wb, db;
    logic [31:0] d1;
    rand_mem(6);
    run_job(6, 32'd5, 5'd2, t, wb, db);
    build_expect(6, 32'd5, 2, t);
    wait_done(db, 30, "partial");
    step();
    checks++;
    if (wq_addr.size() != wb + 2) begin
      failures++;
      $display("FAIL partial count: got %0d writes expected 2", wq_addr.size() - wb);
    end else begin
      d1 = wq_data[wb + 1];
      if (wq_wren[wb] !== 4'hF || wq_wren[wb + 1] !== 4'b0011 || wq_addr[wb + 1] !== 32'd1 ||
          d1[31:16] !== 16'd0 || wq_data[wb] !== exp_data[0] || d1 !== exp_data[1]) begin
        failures++;
        $display("FAIL partial words: got wren=%b/%b addr1=%h data=%h/%h expected 1111/0011 1 %h/%h",
                 wq_wren[wb], wq_wren[wb + 1], wq_addr[wb + 1], wq_data[wb], d1, exp_data[0], exp_data[1]);
      end
    end
    checks++;
    if (done_cyc != t + 9) begin
      failures++;
      $display("FAIL partial done: got %0d expected %0d", done_cyc, t + 9);
    end
  endtask

  task automatic test_random();
    int t, wb, db, n, sh;
    logic [31:0] b;
    for (int j = 0; j < 8; j++) begin
      n  = $urandom_range(1, 20);
      b  = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 600)) - 32'd300;
      sh = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 10);
      rand_mem(n);
      run_job(n, b, 5'(sh), t, wb, db);
      build_expect(n, b, sh, t);
      wait_done(db, n + 30, "random");
      step();
      checks++;
      if (wq_addr.size() - wb != exp_addr.size()) begin
        failures++;
        $display("FAIL random count: got %0d writes expected %0d", wq_addr.size() - wb, exp_addr.size());
      end else begin
        for (int k = 0; k < exp_addr.size(); k++) begin
          checks++;
          if (wq_addr[wb + k] !== exp_addr[k] || wq_data[wb + k] !== exp_data[k] ||
              wq_wren[wb + k] !== exp_wren[k] || wq_cyc[wb + k] != exp_cyc[k]) begin
            failures++;
            $display("FAIL random write %0d: got addr=%h data=%h wren=%b cyc=%0d expected addr=%h data=%h wren=%b cyc=%0d",
                     k, wq_addr[wb + k], wq_data[wb + k], wq_wren[wb + k], wq_cyc[wb + k],
                     exp_addr[k], exp_data[k], exp_wren[k], exp_cyc[k]);
          end
        end
      end
      checks++;
      if (done_cyc != t + n + 3) begin
        failures++;
        $display("FAIL random done: got %0d expected %0d", done_cyc, t + n + 3);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int t, wb, db;
    rand_mem(8);
    run_job(8, 32'd0, 5'd3, t, wb, db);
    build_expect(8, 32'd0, 3, t);
    step();
    i_conf_outputsize = 32'd2;
    i_conf_bias       = 32'd1000;
    i_start           = 1'b1;
    step();
    i_start = 1'b0;
    wait_done(db, 40, "busy");
    repeat (15) step();
    checks++;
    if (done_cnt - db != 1) begin
      failures++;
      $display("FAIL busy done count: got %0d expected 1", done_cnt - db);
    end
    checks++;
    if (wq_addr.size() - wb != 2 || wq_data[wb] !== exp_data[0] || wq_data[wb + 1] !== exp_data[1]) begin
      failures++;
      $display("FAIL busy writes: got %0d writes expected 2 data %h/%h", wq_addr.size() - wb, exp_data[0], exp_data[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    int t, wb, db, k;
    rand_mem(12);
    run_job(12, 32'd0, 5'd2, t, wb, db);
    for (k = 0; k < 10 && cyc < t + 3; k++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({o_busy, o_done, psum_enb, out_enb, out_wren} !== 8'd0 || psum_addr !== 32'd0 ||
        out_addr !== 32'd0 || out_idat !== 32'd0) begin
      failures++;
      $display("FAIL midreset outputs: got busy=%b enb=%b addr=%h wren=%b expected all 0", o_busy, psum_enb, psum_addr, out_wren);
    end
    rst = 1'b0;
    repeat (20) step();
    checks++;
    if (wq_addr.size() != wb || done_cnt != db) begin
      failures++;
      $display("FAIL midreset quiet: got writes=%0d dones=%0d expected 0 0", wq_addr.size() - wb, done_cnt - db);
    end
    rand_mem(5);
    run_job(5, 32'hFFFF_FFF0, 5'd1, t, wb, db);
    build_expect(5, 32'hFFFF_FFF0, 1, t);
    wait_done(db, 30, "restart");
    step();
    checks++;
    if (wq_addr.size() - wb != 2 || wq_data[wb] !== exp_data[0] || wq_data[wb + 1] !== exp_data[1] ||
        wq_wren[wb + 1] !== 4'b0001 || done_cyc != t + 8) begin
      failures++;
      $display("FAIL restart: got writes=%0d done=%0d expected 2 writes done=%0d", wq_addr.size() - wb, done_cyc, t + 8);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_conf_outputsize = '0;
    i_conf_bias = '0;
    i_conf_shift = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) step();
    test_reset();
    rst = 1'b0;
    step();
    test_saturation();
    test_rounding();
    test_partial();
    test_random();
    test_start_while_busy();
    test_reset_mid_op();
    checks++;
    if (enb_err != 0) begin
      failures++;
      $display("FAIL out_enb: got %0d cycles differing from |out_wren expected 0", enb_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
